// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic RstZero = 1'b0;

    // Bit counter must reach WIDTH-1; keep at least one bit for tiny widths.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR for the carry.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic c_o
);

    logic s0, c0, c1;

    half_adder u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s0),
        .c_o (c0)
    );

    half_adder u_ha1 (
        .a_i (s0),
        .b_i (cin_i),
        .s_o (s_o),
        .c_o (c1)
    );

    assign c_o = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; building block of the full-adder cell.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder with valid/ready handshakes on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d, cout_q, cout_d;
    logic              fa_s, fa_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    full_adder_cell u_fa (
        .a_i   (a_sh_q[0]),
        .b_i   (b_sh_q[0]),
        .cin_i (carry_q),
        .s_o   (fa_s),
        .c_o   (fa_c)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = RstZero;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = {RstZero, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {RstZero, b_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    sum_d   = sum_sh_d;
                    cout_d  = fa_c;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on the last bit.
                    ovf_d   = carry_q ^ fa_c;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            a_sh_q   <= {WIDTH{RstZero}};
            b_sh_q   <= {WIDTH{RstZero}};
            sum_sh_q <= {WIDTH{RstZero}};
            sum_q    <= {WIDTH{RstZero}};
            cnt_q    <= {CntW{RstZero}};
            carry_q  <= RstZero;
            cout_q   <= RstZero;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= RstZero;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .busy_o      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
    endtask

    // Accept one operand set; leaves the DUT in RUN right after the accept edge.
    task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input bit noise, input int hold);
        logic [W:0] full;
        logic       exp_ovf;
        full    = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
        exp_ovf = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
        accept(ta, tb_, tc);
        if (noise) begin
            in_valid = 1'b1; a = ~ta; b = ta ^ 8'h5a; cin = ~tc;
        end
        check("busy_run", 32'(busy), 32'd1);
        check("in_ready_run", 32'(in_ready), 32'd0);
        repeat (W - 1) begin
            @(posedge clk); #1;
        end
        check("out_valid_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("out_valid", 32'(out_valid), 32'd1);
        check("sum", 32'(sum), 32'(full[W-1:0]));
        check("cout", 32'(cout), 32'(full[W]));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(full[W-1:0]));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        rst_n = 1'b0;
        #13;
        check_idle_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
        run_op(8'h3C, 8'h11, 1'b0, 1'b1, 5);

        // Abort mid-operation after the 4th RUN bit; previous sum 8'h4D must clear.
        accept(8'h55, 8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder with a valid/ready front end. It accepts two WIDTH-bit operands and a carry-in, then adds them LSB-first over WIDTH clock cycles using a single one-bit full-adder cell built from half adders. It returns the WIDTH-bit sum and carry-out through a valid/ready back end. It is the sequential stage directly downstream of the half-adder cell and reuses that cell's sum/carry function once per clock, trading latency for area.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH ≥ 2.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a, b and cin.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout are valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready: load a_sh ← a, b_sh ← b, carry ← cin, bit counter ← 0; go to RUN.
- RUN, one bit per cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry; c = majority(a_sh[0], b_sh[0], carry).
  - sum_sh ← {s, sum_sh[WIDTH-1:1]}; a_sh, b_sh shift right by one; carry ← c; counter increments.
  - When counter == WIDTH-1 the last bit is processed: sum ← final sum_sh, cout ← c; go to DONE.
- DONE
  - out_valid = 1; sum and cout are held stable.
  - On out_ready: go to IDLE.
- Inputs are ignored outside IDLE; in_valid during RUN or DONE has no effect.
- Arithmetic is modulo 2^WIDTH. {cout, sum} always equals a + b + cin.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, sum 0, cout 0, ovf 0, all shift registers 0, counter 0.
- Reset asserted mid-operation aborts the operation immediately. The operation is not resumed, and the next accepted operation is computed correctly.

## Timing
- Accept edge E0 moves the FSM to RUN. Bits are processed on edges E1..EWIDTH.
- out_valid rises after edge EWIDTH, so latency is WIDTH cycles from the accept edge.
- The out_ready handshake in DONE returns the FSM to IDLE on the next edge; in_ready is high the following cycle.
- Minimum initiation interval is WIDTH+2 cycles. There is no overlap of consecutive operations.
- in_ready, out_valid and busy are decoded directly from registered state. No combinational path exists from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - ovf port exists.
  - On the last RUN bit, ovf ← carry-into-MSB ^ carry-out-of-MSB; held through DONE.
  - Cleared to 0 on reset and on the next accept.
- SERIAL_ADDER_OVF_EN undefined: ovf port and its logic are absent. All other behaviour is identical.

## Structure
- serial_adder_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - counter-width constant/function, $clog2(WIDTH);
  - the reset value of zero shared by the datapath registers.
- Sub-module full_adder_cell:
  - two half-adder instances plus an OR for carry;
  - ports a, b, cin, s, c;
  - one instance sits in the datapath.

## Test plan
- WIDTH=8, a=8'h00, b=8'h00, cin=0 → after 8 cycles out_valid=1, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1.
- a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1.
- Hold out_ready=0 for 5 cycles in DONE → out_valid stays 1 and sum is stable. Drive in_valid with a different operand during RUN → in_ready=0 and the operand is ignored.
- Drop rst_n after the 4th RUN bit → all outputs return to reset values at once. Then send 8'h12+8'h34 → sum=8'h46, cout=0.
